// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing helpers
package fifo_pkg;

  // Address width for a FIFO of the given depth; never below 1 bit.
  function automatic int fifo_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Depth must be a power of two and at least 2 so pointer wrap and full/empty decode work.
  function automatic bit fifo_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - producer/consumer bundle for sync_fifo_flags
interface sync_fifo_flags_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = fifo_aw(DEPTH);

  logic                  flush;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [AW:0]           af_thresh;
  logic [AW:0]           ae_thresh;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [AW:0]           count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, din, wr_en, rd_en, af_thresh, ae_thresh,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, din, wr_en, rd_en, af_thresh, ae_thresh,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sdp_ram.sv
// rtl/fifo_sdp_ram.sv - simple dual-port RAM, sync write, async read
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [fifo_aw(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [fifo_aw(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Asynchronous read so the head word is visible in the same cycle.
  always_comb begin
    rdata = mem[raddr];
  end
endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with count, thresholds and sticky error flags
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_flags_if.slave bus
);
  localparam int AW = fifo_aw(DEPTH);

  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two and >= 2");
  end

  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  empty, full, rd_acc, wr_acc, mem_we;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Occupancy and flags decoded from the registered pointers only.
  always_comb begin
    count        = wr_ptr_q - rd_ptr_q;
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    bus.count        = count;
    bus.empty        = empty;
    bus.full         = full;
    bus.almost_full  = (count >= bus.af_thresh);
    bus.almost_empty = (count <= bus.ae_thresh);
    bus.overflow     = overflow_q;
    bus.underflow    = underflow_q;
  end

  // Accept rules: a write into a full FIFO is taken only when a pop frees the slot.
  always_comb begin
    rd_acc = bus.rd_en & ~empty;
    wr_acc = bus.wr_en & (~full | rd_acc);
    mem_we = wr_acc & ~bus.flush;
  end

  // Next-state for pointers and sticky errors; flush overrides all traffic.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (bus.wr_en & ~wr_acc) overflow_d  = 1'b1;
      if (bus.rd_en & empty)   underflow_d = 1'b1;
    end
  end

  // Pointer and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_sdp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(bus.din),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(ram_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    // Show-ahead: the head word drives dout directly.
    always_comb begin
      bus.dout = ram_rdata;
    end
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Registered read: capture the popped word, hold otherwise, clear on flush.
    always_comb begin
      dout_d = dout_q;
      if (bus.flush)  dout_d = '0;
      else if (rd_acc) dout_d = ram_rdata;
    end

    // Output data register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    // Registered read data onto the bus.
    always_comb begin
      bus.dout = dout_q;
    end
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized self-checking bench, FWFT=1 and FWFT=0 side by side
module tb_sync_fifo_flags;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();
  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: contents as a queue, plus sticky flags and the registered output word.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf;
  logic [DW-1:0] m_dreg;
  int            af_th, ae_th;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit f, input bit w, input bit r, input logic [DW-1:0] d);
    bus1.flush = f; bus1.wr_en = w; bus1.rd_en = r; bus1.din = d;
    bus0.flush = f; bus0.wr_en = w; bus0.rd_en = r; bus0.din = d;
    bus1.af_thresh = af_th[AW:0]; bus1.ae_thresh = ae_th[AW:0];
    bus0.af_thresh = af_th[AW:0]; bus0.ae_thresh = ae_th[AW:0];
  endtask

  task automatic check_all(input string ph);
    int n;
    n = q.size();
    check_eq({ph, "_count1"}, bus1.count, n);
    check_eq({ph, "_count0"}, bus0.count, n);
    check_eq({ph, "_empty1"}, bus1.empty, n == 0);
    check_eq({ph, "_empty0"}, bus0.empty, n == 0);
    check_eq({ph, "_full1"}, bus1.full, n == DEPTH);
    check_eq({ph, "_full0"}, bus0.full, n == DEPTH);
    check_eq({ph, "_af1"}, bus1.almost_full, n >= af_th);
    check_eq({ph, "_af0"}, bus0.almost_full, n >= af_th);
    check_eq({ph, "_ae1"}, bus1.almost_empty, n <= ae_th);
    check_eq({ph, "_ae0"}, bus0.almost_empty, n <= ae_th);
    check_eq({ph, "_ovf1"}, bus1.overflow, m_ovf);
    check_eq({ph, "_ovf0"}, bus0.overflow, m_ovf);
    check_eq({ph, "_unf1"}, bus1.underflow, m_unf);
    check_eq({ph, "_unf0"}, bus0.underflow, m_unf);
    check_eq({ph, "_dout0"}, bus0.dout, m_dreg);
    if (n > 0) check_eq({ph, "_dout1"}, bus1.dout, q[0]);
  endtask

  // Called at posedge+1: drive, settle, check current state, advance model, step one clock.
  task automatic cycle(input string ph, input bit f, input bit w, input bit r, input logic [DW-1:0] d);
    bit was_empty, do_rd, do_wr;
    drive(f, w, r, d);
    #1;
    check_all(ph);
    if (f) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dreg = '0;
    end else begin
      was_empty = (q.size() == 0);
      do_rd = r && !was_empty;
      do_wr = w && (q.size() < DEPTH || do_rd);
      if (do_rd) m_dreg = q.pop_front();
      if (do_wr) q.push_back(d);
      if (w && !do_wr) m_ovf = 1;
      if (r && was_empty) m_unf = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset(input string ph);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 0; m_unf = 0; m_dreg = '0;
    check_all(ph);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    af_th = 12; ae_th = 3;
    m_ovf = 0; m_unf = 0; m_dreg = '0;
    drive(0, 0, 0, '0);
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. fill 0x01..0x10, then a rejected 17th write
    for (int i = 1; i <= DEPTH; i++) cycle("fill", 0, 1, 0, DW'(i));
    check_eq("t1_full", bus1.full, 1);
    cycle("ovw", 0, 1, 0, 8'hEE);
    check_eq("t1_ovf", bus1.overflow, 1);
    check_eq("t1_cnt16", bus0.count, 16);

    // 2. drain, then one extra read
    for (int i = 1; i <= DEPTH; i++) cycle("drain", 0, 0, 1, '0);
    check_eq("t2_last_reg", bus0.dout, 8'h10);
    cycle("unf", 0, 0, 1, '0);
    check_eq("t2_unf", bus1.underflow, 1);

    // 3. full pass-through for 40 cycles
    cycle("fl3", 1, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) cycle("fill3", 0, 1, 0, DW'(i));
    for (int i = 0; i < 40; i++) cycle("pass", 0, 1, 1, DW'(8'hA0 + i));
    check_eq("t3_cnt", bus1.count, 16);
    check_eq("t3_noovf", bus0.overflow, 0);

    // 4. simultaneous access on empty
    cycle("fl4", 1, 0, 0, '0);
    cycle("emp_rw", 0, 1, 1, 8'h55);
    check_eq("t4_dout", bus1.dout, 8'h55);
    check_eq("t4_unf", bus1.underflow, 1);

    // 5. thresholds: 13 writes then 11 reads
    cycle("fl5", 1, 0, 0, '0);
    for (int i = 0; i < 13; i++) cycle("thw", 0, 1, 0, DW'($urandom));
    for (int i = 0; i < 11; i++) cycle("thr", 0, 0, 1, '0);

    // 6. flush with a write at count 7 and overflow set, then async reset mid-burst
    for (int i = 0; i < DEPTH; i++) cycle("fill6", 0, 1, 0, DW'($urandom));
    for (int i = 0; i < 9; i++) cycle("rd6", 0, 0, 1, '0);
    cycle("ovf6", 0, 0, 0, '0);
    cycle("fl6", 1, 1, 0, 8'h77);
    check_eq("t6_cnt", bus1.count, 0);
    check_eq("t6_ovf", bus0.overflow, 0);
    for (int i = 0; i < 5; i++) cycle("burst", 0, 1, 0, DW'(i));
    drive(0, 1, 1, 8'h99);
    async_reset("arst");

    // Randomized traffic with varying thresholds, rare flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        af_th = $urandom_range(0, 31);
        ae_th = $urandom_range(0, 31);
      end
      if ($urandom_range(0, 999) == 0) begin
        drive(0, 1, 0, '0);
        async_reset("rnd_arst");
      end else begin
        cycle((i < 1500) ? "rnd_a" : "rnd_b",
              $urandom_range(0, 199) == 0,
              $urandom_range(0, 99) < ((i < 1500) ? 60 : 40),
              $urandom_range(0, 99) < ((i < 1500) ? 40 : 60),
              DW'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
